fwd_pipe: RTL and testbench



---
 rtl/fwd_pipe_pkg.sv | 33 +++
 rtl/fwd_pipe_match.sv | 60 ++++++
 rtl/fwd_pipe.sv | 140 ++++++++++++++
 tb/tb_fwd_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pipe_pkg.sv
// Shared definitions for the fwd_pipe forwarding network: entry layout, register-zero
// index and the late-result forwarding mode.
package fwd_pipe_pkg;

  localparam int unsigned GPR_ZERO = 0;

  typedef enum logic {
    LATE_REG,
    LATE_BYPASS
  } late_mode_e;

  // Flattened entry layout, LSB first: wdata, waddr, dok, wen, v
  function automatic int unsigned ent_w(input int unsigned aw, input int unsigned dw);
    return dw + aw + 3;
  endfunction

  function automatic int unsigned off_waddr(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned off_dok(input int unsigned aw, input int unsigned dw);
    return dw + aw;
  endfunction

  function automatic int unsigned off_wen(input int unsigned aw, input int unsigned dw);
    return dw + aw + 1;
  endfunction

  function automatic int unsigned off_v(input int unsigned aw, input int unsigned dw);
    return dw + aw + 2;
  endfunction

endpackage

// File: rtl/fwd_pipe_match.sv
// One operand read port: resolves an address against the flattened in-flight chain
// with youngest-first priority, optionally bypassing the late result combinationally.
module fwd_pipe_match
  import fwd_pipe_pkg::*;
#(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LATE_STAGE = 1,
  parameter late_mode_e  LATE_MODE  = LATE_REG
) (
  input  logic [DEPTH*ent_w(ADDR_W, DATA_W)-1:0] chain_i,
  input  logic [ADDR_W-1:0]                      rd_addr_i,
  input  logic                                   late_valid_i,
  input  logic [DATA_W-1:0]                      late_data_i,
  output logic                                   hit_o,
  output logic                                   dok_o,
  output logic [DATA_W-1:0]                      data_o
);

  localparam int unsigned EW = ent_w(ADDR_W, DATA_W);

  logic [DEPTH-1:0]  match;
  logic [DEPTH-1:0]  dok;
  logic [DEPTH-1:0]  late;
  logic [DATA_W-1:0] wdata [DEPTH];
  logic              win_late;

  for (genvar g = 0; g < DEPTH; g++) begin : g_unpack
    localparam int unsigned B = g * EW;
    assign match[g] = chain_i[B + off_v(ADDR_W, DATA_W)]
                    & chain_i[B + off_wen(ADDR_W, DATA_W)]
                    & (chain_i[B + off_waddr(DATA_W) +: ADDR_W] == rd_addr_i)
                    & (rd_addr_i != ADDR_W'(GPR_ZERO));
    assign dok[g]   = chain_i[B + off_dok(ADDR_W, DATA_W)];
    assign wdata[g] = chain_i[B +: DATA_W];
    assign late[g]  = (g == LATE_STAGE);
  end

  // Scan oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    hit_o    = 1'b0;
    dok_o    = 1'b0;
    data_o   = '0;
    win_late = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (match[DEPTH-1-k]) begin
        hit_o    = 1'b1;
        dok_o    = dok[DEPTH-1-k];
        data_o   = wdata[DEPTH-1-k];
        win_late = late[DEPTH-1-k];
      end
    end
    if (LATE_MODE == LATE_BYPASS && hit_o && !dok_o && win_late && late_valid_i) begin
      dok_o  = 1'b1;
      data_o = late_data_i;
    end
  end

endmodule

// File: rtl/fwd_pipe.sv
// In-flight result tracker and operand forwarding network behind the issue point.
// Optional combinational late-result bypass: define FWD_LATE_BYPASS_EN.
module fwd_pipe
  import fwd_pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned RD_PORTS   = 2,
  parameter int unsigned LATE_STAGE = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_wen,
  input  logic [ADDR_W-1:0]            in_waddr,
  input  logic                         in_dok,
  input  logic [DATA_W-1:0]            in_wdata,
  input  logic                         late_valid,
  input  logic [DATA_W-1:0]            late_data,
  input  logic                         ext_stall,
  input  logic [DEPTH-1:0]             kill,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  input  logic [RD_PORTS*DATA_W-1:0]   rd_rf,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic [RD_PORTS-1:0]          rd_hit,
  output logic                         hazard,
  output logic                         wb_valid,
  output logic                         wb_wen,
  output logic [ADDR_W-1:0]            wb_waddr,
  output logic [DATA_W-1:0]            wb_wdata
);

`ifdef FWD_LATE_BYPASS_EN
  localparam late_mode_e LATE_MODE = LATE_BYPASS;
`else
  localparam late_mode_e LATE_MODE = LATE_REG;
`endif

  localparam int unsigned EW = ent_w(ADDR_W, DATA_W);

  logic [DEPTH-1:0]  v_q, v_d, wen_q, wen_d, dok_q, dok_d;
  logic [ADDR_W-1:0] waddr_q [DEPTH];
  logic [ADDR_W-1:0] waddr_d [DEPTH];
  logic [DATA_W-1:0] wdata_q [DEPTH];
  logic [DATA_W-1:0] wdata_d [DEPTH];

  // Kill and late capture act on the pre-advance slot; the shift then carries the result.
  logic [DEPTH-1:0]  v_p, dok_p;
  logic [DATA_W-1:0] wdata_p [DEPTH];
  logic              issue;

  logic [DEPTH*EW-1:0] chain;
  logic [RD_PORTS-1:0] m_hit, m_dok;
  logic [DATA_W-1:0]   m_data [RD_PORTS];

  assign hazard   = |(m_hit & ~m_dok);
  assign in_ready = ~ext_stall & ~hazard;
  assign issue    = in_valid & in_ready;

  always_comb begin
    v_p     = v_q & ~kill;
    dok_p   = dok_q;
    wdata_p = wdata_q;
    if (late_valid && v_q[LATE_STAGE] && !dok_q[LATE_STAGE]) begin
      dok_p[LATE_STAGE]   = 1'b1;
      wdata_p[LATE_STAGE] = late_data;
    end
  end

  always_comb begin
    v_d     = v_p;
    wen_d   = wen_q;
    dok_d   = dok_p;
    waddr_d = waddr_q;
    wdata_d = wdata_p;
    if (!ext_stall) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        v_d[k]     = v_p[k-1];
        wen_d[k]   = wen_q[k-1];
        dok_d[k]   = dok_p[k-1];
        waddr_d[k] = waddr_q[k-1];
        wdata_d[k] = wdata_p[k-1];
      end
      v_d[0]     = issue;
      wen_d[0]   = issue & in_wen;
      dok_d[0]   = issue & in_dok;
      waddr_d[0] = issue ? in_waddr : '0;
      wdata_d[0] = issue ? in_wdata : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      wen_q   <= '0;
      dok_q   <= '0;
      waddr_q <= '{default: '0};
      wdata_q <= '{default: '0};
    end else begin
      v_q     <= v_d;
      wen_q   <= wen_d;
      dok_q   <= dok_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign chain[g*EW +: EW] = {v_q[g], wen_q[g], dok_q[g], waddr_q[g], wdata_q[g]};
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
    fwd_pipe_match #(
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .LATE_STAGE (LATE_STAGE),
      .LATE_MODE  (LATE_MODE)
    ) u_match (
      .chain_i      (chain),
      .rd_addr_i    (rd_addr[p*ADDR_W +: ADDR_W]),
      .late_valid_i (late_valid),
      .late_data_i  (late_data),
      .hit_o        (m_hit[p]),
      .dok_o        (m_dok[p]),
      .data_o       (m_data[p])
    );
    assign rd_hit[p]                  = m_hit[p];
    assign rd_data[p*DATA_W +: DATA_W] = (m_hit[p] & m_dok[p]) ? m_data[p]
                                                               : rd_rf[p*DATA_W +: DATA_W];
  end

  assign wb_valid = v_q[DEPTH-1];
  assign wb_wen   = wen_q[DEPTH-1];
  assign wb_waddr = waddr_q[DEPTH-1];
  assign wb_wdata = wdata_q[DEPTH-1];

endmodule

// File: tb/tb_fwd_pipe.sv
// Directed bench for fwd_pipe (DEPTH=3, LATE_STAGE=1): vector table plus hand sequences
// for load-use/late capture and asynchronous reset.
module tb_fwd_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_wen, in_dok;
  logic [4:0]  in_waddr;
  logic [31:0] in_wdata;
  logic        late_valid;
  logic [31:0] late_data;
  logic        ext_stall;
  logic [2:0]  kill;
  logic [9:0]  rd_addr;
  logic [63:0] rd_rf, rd_data;
  logic [1:0]  rd_hit;
  logic        hazard, wb_valid, wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Register file stand-in: value encodes the address read.
  assign rd_rf[31:0]  = 32'hA000_0000 | {27'b0, rd_addr[4:0]};
  assign rd_rf[63:32] = 32'hA000_0000 | {27'b0, rd_addr[9:5]};

  fwd_pipe #(
    .DATA_W(32), .ADDR_W(5), .DEPTH(3), .RD_PORTS(2), .LATE_STAGE(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
    .in_waddr(in_waddr), .in_dok(in_dok), .in_wdata(in_wdata), .late_valid(late_valid),
    .late_data(late_data), .ext_stall(ext_stall), .kill(kill), .rd_addr(rd_addr),
    .rd_rf(rd_rf), .rd_data(rd_data), .rd_hit(rd_hit), .hazard(hazard),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
  );

  typedef struct {
    logic        iv, iwen;
    logic [4:0]  iaddr;
    logic        idok;
    logic [31:0] idata;
    logic        stall;
    logic [2:0]  kl;
    logic [4:0]  ra0, ra1;
    logic [1:0]  e_hit;
    logic [31:0] e_d0, e_d1;
    logic        e_hz, e_rdy, e_wbv;
    logic [4:0]  e_wba;
    logic [31:0] e_wbd;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic iv, input logic iwen, input logic [4:0] iaddr, input logic idok,
    input logic [31:0] idata, input logic stall, input logic [2:0] kl,
    input logic [4:0] ra0, input logic [4:0] ra1, input logic [1:0] e_hit,
    input logic [31:0] e_d0, input logic [31:0] e_d1, input logic e_hz, input logic e_rdy,
    input logic e_wbv, input logic [4:0] e_wba, input logic [31:0] e_wbd);
    vec_t t;
    t.iv = iv; t.iwen = iwen; t.iaddr = iaddr; t.idok = idok; t.idata = idata;
    t.stall = stall; t.kl = kl; t.ra0 = ra0; t.ra1 = ra1; t.e_hit = e_hit;
    t.e_d0 = e_d0; t.e_d1 = e_d1; t.e_hz = e_hz; t.e_rdy = e_rdy; t.e_wbv = e_wbv;
    t.e_wba = e_wba; t.e_wbd = e_wbd;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    in_valid = 0; in_wen = 0; in_waddr = '0; in_dok = 0; in_wdata = '0;
    late_valid = 0; late_data = '0; ext_stall = 0; kill = '0; rd_addr = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic issue(input logic [4:0] a, input logic dok, input logic [31:0] d);
    in_valid = 1; in_wen = 1; in_waddr = a; in_dok = dok; in_wdata = d;
  endtask

  initial begin
    // iv wen addr dok data stall kill ra0 ra1 | hit d0 d1 hz rdy wbv wba wbd
    tbl[0]  = mk(0,0,0,0,0,        0,3'b000, 8,9, 2'b00, 32'hA000_0008, 32'hA000_0009, 0,1,0, 0,0);
    tbl[1]  = mk(1,1,8,1,32'h11,   0,3'b000, 8,0, 2'b00, 32'hA000_0008, 32'hA000_0000, 0,1,0, 0,0);
    tbl[2]  = mk(1,1,4,1,32'h1,    0,3'b000, 8,0, 2'b01, 32'h11,        32'hA000_0000, 0,1,0, 0,0);
    tbl[3]  = mk(1,1,4,1,32'h2,    0,3'b000, 4,8, 2'b11, 32'h1,         32'h11,        0,1,0, 0,0);
    tbl[4]  = mk(1,1,0,1,32'h7,    0,3'b000, 4,0, 2'b01, 32'h2,         32'hA000_0000, 0,1,1, 8,32'h11);
    tbl[5]  = mk(0,0,0,0,0,        0,3'b000, 0,4, 2'b10, 32'hA000_0000, 32'h2,         0,1,1, 4,32'h1);
    tbl[6]  = mk(1,1,6,1,32'h66,   0,3'b000, 4,0, 2'b01, 32'h2,         32'hA000_0000, 0,1,1, 4,32'h2);
    tbl[7]  = mk(1,1,3,1,32'h33,   1,3'b000, 6,0, 2'b01, 32'h66,        32'hA000_0000, 0,0,1, 0,32'h7);
    tbl[8]  = mk(1,1,3,1,32'h33,   1,3'b000, 6,0, 2'b01, 32'h66,        32'hA000_0000, 0,0,1, 0,32'h7);
    tbl[9]  = mk(1,1,3,1,32'h33,   1,3'b000, 6,0, 2'b01, 32'h66,        32'hA000_0000, 0,0,1, 0,32'h7);
    tbl[10] = mk(0,0,0,0,0,        0,3'b000, 6,0, 2'b01, 32'h66,        32'hA000_0000, 0,1,1, 0,32'h7);
    tbl[11] = mk(0,0,0,0,0,        0,3'b000, 6,0, 2'b01, 32'h66,        32'hA000_0000, 0,1,0, 0,0);
    tbl[12] = mk(0,0,0,0,0,        0,3'b000, 6,0, 2'b01, 32'h66,        32'hA000_0000, 0,1,1, 6,32'h66);
    tbl[13] = mk(0,0,0,0,0,        0,3'b000, 6,0, 2'b00, 32'hA000_0006, 32'hA000_0000, 0,1,0, 0,0);
    tbl[14] = mk(1,1,5,0,0,        0,3'b000, 0,0, 2'b00, 32'hA000_0000, 32'hA000_0000, 0,1,0, 0,0);
    tbl[15] = mk(0,0,0,0,0,        0,3'b000, 0,5, 2'b10, 32'hA000_0000, 32'hA000_0005, 1,0,0, 0,0);
    tbl[16] = mk(0,0,0,0,0,        0,3'b010, 0,5, 2'b10, 32'hA000_0000, 32'hA000_0005, 1,0,0, 0,0);
    tbl[17] = mk(0,0,0,0,0,        0,3'b000, 0,5, 2'b00, 32'hA000_0000, 32'hA000_0005, 0,1,0, 0,0);
    tbl[18] = mk(0,0,0,0,0,        0,3'b000, 0,5, 2'b00, 32'hA000_0000, 32'hA000_0005, 0,1,0, 0,0);

    idle();
    rst_n   = 0;
    rd_addr = {5'd9, 5'd8};
    #2;
    chk("rst.wb_valid", 32'(wb_valid), 32'd0);
    chk("rst.wb_wen",   32'(wb_wen),   32'd0);
    chk("rst.wb_waddr", 32'(wb_waddr), 32'd0);
    chk("rst.wb_wdata", wb_wdata,      32'd0);
    chk("rst.rd_hit",   32'(rd_hit),   32'd0);
    chk("rst.hazard",   32'(hazard),   32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.rd_data0", rd_data[31:0],  32'hA000_0008);
    chk("rst.rd_data1", rd_data[63:32], 32'hA000_0009);
    #10 rst_n = 1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      idle();
      in_valid = tbl[i].iv; in_wen = tbl[i].iwen; in_waddr = tbl[i].iaddr;
      in_dok = tbl[i].idok; in_wdata = tbl[i].idata; ext_stall = tbl[i].stall;
      kill = tbl[i].kl; rd_addr = {tbl[i].ra1, tbl[i].ra0};
      @(negedge clk);
      chk($sformatf("t%0d.rd_hit", i),   32'(rd_hit),   32'(tbl[i].e_hit));
      chk($sformatf("t%0d.rd_data0", i), rd_data[31:0],  tbl[i].e_d0);
      chk($sformatf("t%0d.rd_data1", i), rd_data[63:32], tbl[i].e_d1);
      chk($sformatf("t%0d.hazard", i),   32'(hazard),   32'(tbl[i].e_hz));
      chk($sformatf("t%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("t%0d.wb_valid", i), 32'(wb_valid), 32'(tbl[i].e_wbv));
      if (tbl[i].e_wbv) begin
        chk($sformatf("t%0d.wb_wen", i),   32'(wb_wen),   32'd1);
        chk($sformatf("t%0d.wb_waddr", i), 32'(wb_waddr), 32'(tbl[i].e_wba));
        chk($sformatf("t%0d.wb_wdata", i), wb_wdata,      tbl[i].e_wbd);
      end
    end

    // Load-use on r9 with late data arriving at stage 1.
    next_cycle();
    issue(5'd9, 1'b0, 32'h0);
    @(negedge clk);
    chk("lu0.in_ready", 32'(in_ready), 32'd1);

    next_cycle();
    issue(5'd10, 1'b1, 32'h22);
    rd_addr = {5'd9, 5'd0};
    @(negedge clk);
    chk("lu1.rd_hit",   32'(rd_hit),   32'b10);
    chk("lu1.hazard",   32'(hazard),   32'd1);
    chk("lu1.in_ready", 32'(in_ready), 32'd0);
    chk("lu1.rd_data1", rd_data[63:32], 32'hA000_0009);

    next_cycle();
    issue(5'd10, 1'b1, 32'h22);
    rd_addr = {5'd9, 5'd0};
    late_valid = 1; late_data = 32'hABCD;
    @(negedge clk);
    chk("lu2.rd_hit", 32'(rd_hit), 32'b10);
`ifdef FWD_LATE_BYPASS_EN
    chk("lu2.rd_data1", rd_data[63:32], 32'hABCD);
    chk("lu2.hazard",   32'(hazard),   32'd0);
    chk("lu2.in_ready", 32'(in_ready), 32'd1);
`else
    chk("lu2.rd_data1", rd_data[63:32], 32'hA000_0009);
    chk("lu2.hazard",   32'(hazard),   32'd1);
    chk("lu2.in_ready", 32'(in_ready), 32'd0);
`endif

    next_cycle();
`ifndef FWD_LATE_BYPASS_EN
    issue(5'd10, 1'b1, 32'h22);
`endif
    rd_addr = {5'd9, 5'd0};
    @(negedge clk);
    chk("lu3.rd_data1", rd_data[63:32], 32'hABCD);
    chk("lu3.hazard",   32'(hazard),   32'd0);
    chk("lu3.wb_valid", 32'(wb_valid), 32'd1);
    chk("lu3.wb_waddr", 32'(wb_waddr), 32'd9);
    chk("lu3.wb_wdata", wb_wdata,      32'hABCD);

    // Late data with no pending entry at stage 1 must not disturb a ready result.
    for (int j = 4; j < 6; j++) begin
      next_cycle();
      late_valid = 1; late_data = 32'hDEAD;
      rd_addr = {5'd0, 5'd10};
      @(negedge clk);
      chk($sformatf("lu%0d.rd_hit", j),   32'(rd_hit),   32'b01);
      chk($sformatf("lu%0d.rd_data0", j), rd_data[31:0], 32'h22);
    end
    next_cycle();
    next_cycle();

    // Asynchronous reset while a hazard is outstanding.
    next_cycle();
    issue(5'd12, 1'b1, 32'h5A);
    next_cycle();
    issue(5'd11, 1'b0, 32'h0);
    next_cycle();
    rd_addr = {5'd0, 5'd11};
    @(negedge clk);
    chk("rs2.hazard", 32'(hazard), 32'd1);
    next_cycle();
    rd_addr = {5'd0, 5'd11};
    @(negedge clk);
    chk("rs3.hazard",   32'(hazard),   32'd1);
    chk("rs3.wb_valid", 32'(wb_valid), 32'd1);
    chk("rs3.wb_waddr", 32'(wb_waddr), 32'd12);
    #2 rst_n = 0;
    #1;
    chk("rsa.wb_valid", 32'(wb_valid), 32'd0);
    chk("rsa.wb_wen",   32'(wb_wen),   32'd0);
    chk("rsa.wb_waddr", 32'(wb_waddr), 32'd0);
    chk("rsa.wb_wdata", wb_wdata,      32'd0);
    chk("rsa.hazard",   32'(hazard),   32'd0);
    chk("rsa.rd_hit",   32'(rd_hit),   32'd0);
    chk("rsa.rd_data0", rd_data[31:0], 32'hA000_000B);
    chk("rsa.in_ready", 32'(in_ready), 32'd1);
    ext_stall = 1;
    #1;
    chk("rsa.in_ready_stall", 32'(in_ready), 32'd0);
    next_cycle();
    rst_n = 1;
    @(negedge clk);
    chk("rsb.wb_valid", 32'(wb_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
